// File: rtl/exibe_pkg.sv
// ----------------------------------------------------------------------------
// exibe_pkg: shared state codes, default timing and a clog2 helper for the
//            sequence playback block.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package exibe_pkg;

  localparam logic [3:0] ST_OCIOSO  = 4'h0;
  localparam logic [3:0] ST_CARREGA = 4'h1;
  localparam logic [3:0] ST_ACENDE  = 4'h2;
  localparam logic [3:0] ST_APAGA   = 4'h3;
  localparam logic [3:0] ST_PROXIMO = 4'h4;
  localparam logic [3:0] ST_FINAL   = 4'hF;
  localparam logic [3:0] ST_ERRO    = 4'h9;

  localparam int T_ON_DEF  = 1000;
  localparam int T_OFF_DEF = 500;

  typedef enum logic [3:0] {
    OCIOSO  = ST_OCIOSO,
    CARREGA = ST_CARREGA,
    ACENDE  = ST_ACENDE,
    APAGA   = ST_APAGA,
    PROXIMO = ST_PROXIMO,
    FINAL   = ST_FINAL
  } estado_t;

  function automatic int clog2(input int valor);
    int bits;
    int resto;
    bits  = 0;
    resto = valor - 1;
    while (resto > 0) begin
      bits  = bits + 1;
      resto = resto >> 1;
    end
    return bits;
  endfunction

endpackage

`default_nettype wire

// File: rtl/exibe_sequencia_temporizador.sv
// ----------------------------------------------------------------------------
// temporizador_exibicao: loadable down-counter that stops at zero.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module temporizador_exibicao #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         carrega,
  input  logic [W-1:0] valor,
  input  logic         conta,
  output logic         zero
);

  logic [W-1:0] contagem;

  always_ff @(posedge clock) begin
    if (!reset) begin
      contagem <= '0;
    end else if (carrega) begin
      contagem <= valor;
    end else if (conta && (contagem != '0)) begin
      contagem <= contagem - W'(1);
    end
  end

  assign zero = (contagem == '0);

endmodule

`default_nettype wire

// File: rtl/exibe_sequencia.sv
// ----------------------------------------------------------------------------
// exibe_sequencia: plays back sequence RAM 0..limite on the LEDs before each
//                  round. Macro EXIBE_ACELERA_EN halves timing in late rounds.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module exibe_sequencia
  import exibe_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 4,
  parameter int T_ON   = T_ON_DEF,
  parameter int T_OFF  = T_OFF_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              iniciar,
  input  logic [ADDR_W-1:0] limite,
  input  logic [DATA_W-1:0] dado_memoria,
  output logic [ADDR_W-1:0] endereco,
  output logic [DATA_W-1:0] leds,
  output logic              ocupado,
  output logic              fim,
  output logic [3:0]        db_estado
);

  localparam int TW = clog2(((T_ON > T_OFF) ? T_ON : T_OFF) + 1);
  localparam logic [TW-1:0] ON_LD  = TW'(T_ON - 1);
  localparam logic [TW-1:0] OFF_LD = TW'(T_OFF - 1);

  estado_t           estado, prox;
  logic [ADDR_W-1:0] limite_reg;
  logic [TW-1:0]     on_ld, off_ld, t_valor;
  logic              t_carrega, t_conta, t_zero;
  logic              lat_lim, clr_end, inc_end, load_led, clr_led;

`ifdef EXIBE_ACELERA_EN
  localparam int T_ON_R  = (T_ON / 2 < 1) ? 1 : T_ON / 2;
  localparam int T_OFF_R = (T_OFF / 2 < 1) ? 1 : T_OFF / 2;
  localparam logic [TW-1:0] ON_LD_R  = TW'(T_ON_R - 1);
  localparam logic [TW-1:0] OFF_LD_R = TW'(T_OFF_R - 1);
  logic rapido;
  // Upper half of the address range means limite_reg >= 2^(ADDR_W-1).
  assign rapido = limite_reg[ADDR_W-1];
  assign on_ld  = rapido ? ON_LD_R  : ON_LD;
  assign off_ld = rapido ? OFF_LD_R : OFF_LD;
`else
  assign on_ld  = ON_LD;
  assign off_ld = OFF_LD;
`endif

  temporizador_exibicao #(.W(TW)) u_temporizador (
    .clock   (clock),
    .reset   (reset),
    .carrega (t_carrega),
    .valor   (t_valor),
    .conta   (t_conta),
    .zero    (t_zero)
  );

  always_ff @(posedge clock) begin
    if (!reset) estado <= OCIOSO;
    else        estado <= prox;
  end

  always_comb begin
    prox      = estado;
    t_carrega = 1'b0;
    t_valor   = on_ld;
    t_conta   = 1'b0;
    lat_lim   = 1'b0;
    clr_end   = 1'b0;
    inc_end   = 1'b0;
    load_led  = 1'b0;
    clr_led   = 1'b0;
    case (estado)
      OCIOSO: begin
        if (iniciar) begin
          lat_lim = 1'b1;
          clr_end = 1'b1;
          prox    = CARREGA;
        end
      end
      CARREGA: begin
        load_led  = 1'b1;
        t_carrega = 1'b1;
        t_valor   = on_ld;
        prox      = ACENDE;
      end
      ACENDE: begin
        if (t_zero) begin
          clr_led   = 1'b1;
          t_carrega = 1'b1;
          t_valor   = off_ld;
          prox      = APAGA;
        end else begin
          t_conta = 1'b1;
        end
      end
      APAGA: begin
        if (t_zero) prox = (endereco == limite_reg) ? FINAL : PROXIMO;
        else        t_conta = 1'b1;
      end
      PROXIMO: begin
        inc_end = 1'b1;
        prox    = CARREGA;
      end
      FINAL:   prox = OCIOSO;
      default: begin
        clr_led = 1'b1;
        prox    = OCIOSO;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      endereco   <= '0;
      leds       <= '0;
      limite_reg <= '0;
    end else begin
      if (lat_lim) limite_reg <= limite;
      if (clr_end)      endereco <= '0;
      else if (inc_end) endereco <= endereco + ADDR_W'(1);
      if (load_led)     leds <= dado_memoria;
      else if (clr_led) leds <= '0;
    end
  end

  always_comb begin
    case (estado)
      OCIOSO, CARREGA, ACENDE, APAGA, PROXIMO, FINAL: db_estado = estado;
      default:                                        db_estado = ST_ERRO;
    endcase
  end

  assign ocupado = (estado != OCIOSO);
  assign fim     = (estado == FINAL);

endmodule

`default_nettype wire

// File: tb/tb_exibe_sequencia.sv
// ----------------------------------------------------------------------------
// tb_exibe_sequencia: scoreboard bench for exibe_sequencia (T_ON=3, T_OFF=2).
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_exibe_sequencia;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 4;
  localparam int T_ON   = 3;
  localparam int T_OFF  = 2;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              iniciar = 1'b0;
  logic [ADDR_W-1:0] limite = '0;
  logic [DATA_W-1:0] dado_memoria;
  logic [ADDR_W-1:0] endereco;
  logic [DATA_W-1:0] leds;
  logic              ocupado;
  logic              fim;
  logic [3:0]        db_estado;

  logic [DATA_W-1:0] mem [16];

  always #5 clock = ~clock;

  assign dado_memoria = mem[endereco];

  exibe_sequencia #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .T_ON   (T_ON),
    .T_OFF  (T_OFF)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .iniciar      (iniciar),
    .limite       (limite),
    .dado_memoria (dado_memoria),
    .endereco     (endereco),
    .leds         (leds),
    .ocupado      (ocupado),
    .fim          (fim),
    .db_estado    (db_estado)
  );

  typedef struct {
    logic [DATA_W-1:0] val;
    int                len;
  } led_t;

  typedef struct {
    int                rel;
    logic [ADDR_W-1:0] addr;
  } fim_t;

  led_t led_q[$];
  fim_t fim_q[$];

  int cyc = 0;
  int start_edge = 0;
  int checks = 0;
  int failures = 0;
  int run_len = 0;
  int occ_cnt = 0;
  logic [DATA_W-1:0] run_val = '0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic int on_t(input int lim);
`ifdef EXIBE_ACELERA_EN
    if (lim >= 8) return (T_ON / 2 < 1) ? 1 : T_ON / 2;
`endif
    return T_ON;
  endfunction

  function automatic int off_t(input int lim);
`ifdef EXIBE_ACELERA_EN
    if (lim >= 8) return (T_OFF / 2 < 1) ? 1 : T_OFF / 2;
`endif
    return T_OFF;
  endfunction

  // Monitor: closes each lit window and each fim pulse against the queues.
  always @(negedge clock) begin
    led_t le;
    fim_t fe;
    if (ocupado) occ_cnt++;
    else         occ_cnt = 0;
    if (leds != '0) begin
      if (run_len == 0) run_val = leds;
      run_len++;
    end else if (run_len != 0) begin
      if (led_q.size() == 0) begin
        chk("led_extra", 32'(run_val), 32'd0);
      end else begin
        le = led_q.pop_front();
        chk("led_value", 32'(run_val), 32'(le.val));
        chk("led_len", 32'(run_len), 32'(le.len));
      end
      run_len = 0;
    end
    if (fim) begin
      if (fim_q.size() == 0) begin
        chk("fim_extra", 32'(fim), 32'd0);
      end else begin
        fe = fim_q.pop_front();
        chk("fim_cycle", 32'(cyc - start_edge + 1), 32'(fe.rel));
        chk("fim_endereco", 32'(endereco), 32'(fe.addr));
        chk("ocupado_span", 32'(occ_cnt), 32'(fe.rel));
      end
    end
  end

  task automatic push_run(input int lim);
    fim_t fe;
    for (int i = 0; i <= lim; i++) led_q.push_back('{val: mem[i], len: on_t(lim)});
    fe.rel  = (lim + 1) * (on_t(lim) + off_t(lim) + 2);
    fe.addr = ADDR_W'(lim);
    fim_q.push_back(fe);
  endtask

  // Returns at the negedge of cycle 1 (the carrega cycle).
  task automatic start(input int lim);
    @(negedge clock);
    limite     = ADDR_W'(lim);
    iniciar    = 1'b1;
    start_edge = cyc + 1;
    @(negedge clock);
    iniciar = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while ((fim_q.size() != 0 || led_q.size() != 0) && n < budget) begin
      @(negedge clock);
      n++;
    end
    chk(name, 32'(fim_q.size() + led_q.size()), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = DATA_W'(1 << (i % 4));

    repeat (2) @(negedge clock);
    chk("rst_endereco", 32'(endereco), 32'd0);
    chk("rst_leds", 32'(leds), 32'd0);
    chk("rst_ocupado", 32'(ocupado), 32'd0);
    chk("rst_fim", 32'(fim), 32'd0);
    chk("rst_db_estado", 32'(db_estado), 32'd0);
    reset = 1'b1;

    // Three elements.
    push_run(2);
    start(2);
    chk("db_carrega", 32'(db_estado), 32'd1);
    @(negedge clock);
    chk("db_acende", 32'(db_estado), 32'd2);
    chk("leds_first", 32'(leds), 32'd1);
    wait_idle("drain_lim2", 100);
    @(negedge clock);
    chk("idle_endereco_2", 32'(endereco), 32'd2);
    chk("idle_db", 32'(db_estado), 32'd0);

    // Single element.
    push_run(0);
    start(0);
    wait_idle("drain_lim0", 100);
    @(negedge clock);
    chk("idle_endereco_0", 32'(endereco), 32'd0);

    // Whole RAM, no wrap.
    push_run(15);
    start(15);
    wait_idle("drain_lim15", 400);
    repeat (3) @(negedge clock);
    chk("idle_endereco_15", 32'(endereco), 32'd15);
    chk("idle_ocupado_15", 32'(ocupado), 32'd0);

    // limite and iniciar changes while busy are ignored.
    push_run(2);
    start(2);
    repeat (4) @(negedge clock);
    limite  = 4'd5;
    iniciar = 1'b1;
    @(negedge clock);
    iniciar = 1'b0;
    wait_idle("drain_midchange", 100);
    repeat (10) @(negedge clock);
    chk("no_restart_ocupado", 32'(ocupado), 32'd0);
    chk("no_restart_endereco", 32'(endereco), 32'd2);

    // Reset during acende of element 1: its window is cut to one cycle.
    led_q.push_back('{val: mem[0], len: T_ON});
    led_q.push_back('{val: mem[1], len: 1});
    start(2);
    repeat (8) @(negedge clock);
    chk("pre_rst_leds", 32'(leds), 32'(mem[1]));
    reset = 1'b0;
    @(negedge clock);
    chk("mid_rst_leds", 32'(leds), 32'd0);
    chk("mid_rst_ocupado", 32'(ocupado), 32'd0);
    chk("mid_rst_db", 32'(db_estado), 32'd0);
    chk("mid_rst_endereco", 32'(endereco), 32'd0);
    reset = 1'b1;
    repeat (30) @(negedge clock);
    chk("drain_rst", 32'(led_q.size() + fim_q.size()), 32'd0);

    // Rounds at and just below the half-range boundary.
    push_run(8);
    start(8);
    wait_idle("drain_lim8", 200);
    push_run(7);
    start(7);
    wait_idle("drain_lim7", 200);
    repeat (5) @(negedge clock);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/exibe_sequencia.md
Name: exibe_sequencia

Overview:
- Playback side of the memory game: before each round it reads sequence RAM from address 0 to the current round limit and lights the LEDs so the player can see the sequence.
- It is the mirror of the jogada-capture/compare path: that path receives player input, this block shows the stored data.
- It sits between the round counter (limite) and the LED outputs, and multiplexes the RAM address while busy.

Parameters:
- ADDR_W, 4, RAM address and limite width.
- DATA_W, 4, RAM word and LED width (one-hot button code).
- T_ON, 1000, clock cycles each element stays lit (1 s at 1 kHz).
- T_OFF, 500, dark cycles after each element.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low: sampled only on the rising edge of clock; 0 resets.
- iniciar  in  1  start request, level-sampled in ocioso.
- limite  in  ADDR_W  last address to show (round index).
- dado_memoria  in  DATA_W  RAM read data, 1-cycle read latency.
- endereco  out  ADDR_W  RAM read address.
- leds  out  DATA_W  registered LED drive.
- ocupado  out  1  high in every state except ocioso.
- fim  out  1  one-cycle pulse when playback completes.
- db_estado  out  4  state code for the debug display.

Behaviour:
- Reset (reset=0 at an edge) forces ocioso from any state, including mid-playback. Reset values: endereco=0, leds=0, ocupado=0, fim=0, db_estado=0, timer=0.
- States and codes:
  - ocioso (0): iniciar=1 latches limite into limite_reg, clears endereco, goes to carrega. Otherwise stays.
  - carrega (1): waits one cycle for RAM latency. At exit latches dado_memoria into leds, loads timer with T_ON-1, goes to acende.
  - acende (2): leds hold the latched word; timer counts down. At 0, leds←0, timer←T_OFF-1, goes to apaga.
  - apaga (3): leds=0; timer counts down. At 0, goes to final if endereco==limite_reg, else to proximo.
  - proximo (4): endereco←endereco+1, goes to carrega.
  - final (F): fim=1 for this single cycle, then goes to ocioso. endereco stays at limite_reg until the next start.
  - Any illegal state: goes to ocioso, db_estado=9.
- Per-element cost is T_ON+T_OFF+2 cycles. With N=limite_reg+1, fim is high in cycle N·(T_ON+T_OFF+2) after the edge that sampled iniciar.
- limite changes while ocupado=1 are ignored; only the latched limite_reg is used.
- iniciar while ocupado=1 is ignored. If iniciar is still high in ocioso after final, a new playback starts immediately (no edge detection).
- limite=0 shows exactly one element. limite=2^ADDR_W-1 shows all words. Termination uses equality, so endereco never wraps.
- dado_memoria=0 is shown as a dark T_ON window and still counts as an element.
- T_ON and T_OFF must each be ≥1. Timer width is clog2(max(T_ON,T_OFF)+1).

Optional Feature:
- Macro EXIBE_ACELERA_EN.
- When defined: if limite_reg ≥ 2^(ADDR_W-1), the lit time is T_ON/2 (integer division, minimum 1) and the dark time is T_OFF/2 (minimum 1). Later rounds play faster. The fim timing formula uses the halved values.
- When undefined: timing is always T_ON/T_OFF, and no comparator logic is synthesized.

Decomposition:
- Shared package exibe_pkg holds:
  - state encoding localparams (ST_OCIOSO=4'h0 … ST_FINAL=4'hF, ST_ERRO=4'h9);
  - default T_ON/T_OFF constants;
  - a clog2 function.
- One sub-module, temporizador_exibicao: loadable down-counter with inputs carrega, valor, conta and output zero. The FSM instantiates it once and shares it between the acende and apaga windows.

Test Plan (bench T_ON=3, T_OFF=2, RAM holds 1,2,4,8,…):
- Reset, then iniciar=1 for one cycle with limite=2 → leds show 0001, 0010, 0100, each for 3 cycles with 2 dark cycles between. fim pulses once in cycle 21. ocupado is high in cycles 1–21.
- limite=0 → one 0001 flash; fim in cycle 7; endereco stays 0.
- limite=15 with all 16 words loaded → endereco runs 0..15 with no wrap; fim in cycle 112.
- limite changed from 2 to 5 and iniciar re-pulsed mid-playback → sequence still ends after address 2, and no restart occurs.
- reset=0 during acende of element 1 → next cycle leds=0, ocupado=0, db_estado=0, and fim is never asserted.
- EXIBE_ACELERA_EN defined, limite=8 → lit time 1 cycle, dark time 1 cycle, fim in cycle 36. With limite=7 → normal timing, fim in cycle 56.
